ahb_master_arbiter: RTL and testbench

Shares the single AHB-Lite master port between several on-core requesters, such as instruction fetch, load/store and a debug port. Each requester issues single, non-burst transfers through a valid/accept handshake. The block sequences each transfer through its AHB address and data phases and returns read data and an error flag to the winning requester. A hang watchdog prevents any requester from stalling forever on a slave that never becomes ready. It sits between the core's bus clients and the address decoder/mux that drives the per-device select lines.

---
 rtl/ahb_master_arbiter.sv | 257 +++++++++++++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_arbiter.sv
// Purpose: arbitrates NUM_REQ single-transfer requesters onto one AHB-Lite master port, with a hang watchdog.
// Latency: handshake -> NONSEQ next cycle -> data phase -> done pulse 3 cycles after handshake at zero wait states.
// Backpressure: gnt only in IDLE; hready low stretches the current phase until the watchdog aborts. Macro ARB_ROUND_ROBIN_EN selects round-robin.
module ahb_master_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    input  logic [NUM_REQ*3-1:0]   req_size,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic                   err,
    output logic [31:0]            rdata,
    output logic [31:0]            haddr,
    output logic                   hwrite,
    output logic [2:0]             hsize,
    output logic [1:0]             htrans,
    output logic [2:0]             hburst,
    output logic [31:0]            hwdata,
    input  logic [31:0]            hrdata,
    input  logic                   hready,
    input  logic                   hresp
);
    localparam int         IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          haddr_q, haddr_d;
    logic [31:0]          hwdata_q, hwdata_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 hwrite_q, hwrite_d;
    logic [2:0]           hsize_q, hsize_d;
    logic [1:0]           htrans_q, htrans_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;
    logic                 errh_q, errh_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 win_vld;
    logic [IDX_W-1:0]     win_idx;
    logic                 hs;
    logic                 timeout;
    logic [31:0]          sel_addr, sel_wdata;
    logic                 sel_write;
    logic [2:0]           sel_size;
    logic [NUM_REQ-1:0]   idx_onehot;

`ifdef ARB_ROUND_ROBIN_EN
    logic [NUM_REQ-1:0]   last_q, last_d;
    int                   rr_last, rr_dist, rr_best;

    // Winner is the asserted request at the smallest distance after the last grantee.
    always_comb begin
        rr_last = 0;
        rr_dist = 0;
        rr_best = NUM_REQ + 1;
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (last_q[i]) rr_last = i;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            rr_dist = i - rr_last;
            if (rr_dist <= 0) rr_dist = rr_dist + NUM_REQ;
            if (req[i] && (rr_dist < rr_best)) begin
                rr_best = rr_dist;
                win_vld = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end

    // Last-grant pointer moves to the winner on every handshake.
    always_comb begin
        last_d = last_q;
        if (hs) last_d = NUM_REQ'(1) << win_idx;
    end

    // Pointer starts at the top index so requester 0 is served first.
    always_ff @(posedge clock) begin
        if (reset) last_q <= NUM_REQ'(1) << (NUM_REQ - 1);
        else       last_q <= last_d;
    end
`else
    // Fixed priority: lowest asserted index wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end
`endif

    assign hs      = (state_q == IDLE) && win_vld;
    assign timeout = !hready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Accept decode and command mux for the current winner; depends only on req and FSM state.
    always_comb begin
        gnt       = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        sel_size  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                gnt[i]    = hs;
                sel_addr  = req_addr[32*i +: 32];
                sel_wdata = req_wdata[32*i +: 32];
                sel_write = req_write[i];
                sel_size  = req_size[3*i +: 3];
            end
        end
    end

    // One-hot of the latched winner, used for the completion pulse.
    always_comb begin
        idx_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_onehot[i] = (idx_q == IDX_W'(i));
        end
    end

    // Transfer sequencer: next state plus all registered bus and completion outputs.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        haddr_d  = haddr_q;
        hwdata_d = hwdata_q;
        rdata_d  = rdata_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        htrans_d = htrans_q;
        done_d   = '0;
        err_d    = 1'b0;
        errh_d   = errh_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                errh_d = 1'b0;
                if (hs) begin
                    state_d  = ADDR;
                    idx_d    = win_idx;
                    wdata_d  = sel_wdata;
                    haddr_d  = sel_addr;
                    hwrite_d = sel_write;
                    hsize_d  = sel_size;
                    htrans_d = HTRANS_NONSEQ;
                end
            end
            ADDR: begin
                if (hready) begin
                    state_d  = DATA;
                    htrans_d = HTRANS_IDLE;
                    cnt_d    = '0;
                    if (hwrite_q) hwdata_d = wdata_q;
                end else if (timeout) begin
                    state_d  = IDLE;
                    htrans_d = HTRANS_IDLE;
                    cnt_d    = '0;
                    done_d   = idx_onehot;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (hready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    errh_d  = 1'b0;
                    done_d  = idx_onehot;
                    err_d   = hresp | errh_q;
                    if (!hwrite_q) rdata_d = hrdata;
                end else if (timeout) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    errh_d  = 1'b0;
                    done_d  = idx_onehot;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // First ERROR cycle is remembered until hready closes the phase.
                    if (hresp) errh_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wdata_q  <= '0;
            haddr_q  <= '0;
            hwdata_q <= '0;
            rdata_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            done_q   <= '0;
            err_q    <= 1'b0;
            errh_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            haddr_q  <= haddr_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            htrans_q <= htrans_d;
            done_q   <= done_d;
            err_q    <= err_d;
            errh_q   <= errh_d;
            cnt_q    <= cnt_d;
        end
    end

    assign haddr  = haddr_q;
    assign hwrite = hwrite_q;
    assign hsize  = hsize_q;
    assign htrans = htrans_q;
    assign hburst = 3'b000;
    assign hwdata = hwdata_q;
    assign done   = done_q;
    assign err    = err_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: two requesters, watchdog of 4 cycles.
// Completions are predicted into a scoreboard queue at handshake time and checked when done pulses.
// Bus-phase outputs are checked inline at fixed cycle offsets from each handshake.
module tb_ahb_master_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req, req_write, gnt, done;
    logic [63:0] req_addr, req_wdata;
    logic [5:0]  req_size;
    logic        err, hwrite, hready, hresp;
    logic [31:0] rdata, haddr, hwdata, hrdata;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;

    typedef struct {
        logic [1:0]  done;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [31:0] mdl_rdata = 32'h0;
    logic        prev_done = 1'b0;

    ahb_master_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .req(req), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .htrans(htrans),
        .hburst(hburst), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic expect_done(input logic [1:0] d, input logic e, input logic [31:0] r, input int lat);
        exp_t x;
        x.done  = d;
        x.err   = e;
        x.rdata = r;
        x.cyc   = cyc + lat;
        sb.push_back(x);
    endtask

    task automatic drive_cmd(input int i, input logic w, input logic [31:0] a,
                             input logic [31:0] wd, input logic [2:0] sz);
        req[i]                = 1'b1;
        req_write[i]          = w;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = wd;
        req_size[3*i +: 3]    = sz;
    endtask

    // Completion monitor: every done pulse must match the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && done != 2'b00) begin
                check("done_gap", 32'(prev_done), 32'd0);
                check("done_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("done_vec", 32'(done), 32'(e.done));
                    check("done_err", 32'(err), 32'(e.err));
                    check("done_rdata", rdata, e.rdata);
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            prev_done = !reset && (done != 2'b00);
        end
    end

    initial begin
        logic [1:0] eg;
        reset     = 1'b1;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_size  = '0;
        hrdata    = '0;
        hready    = 1'b1;
        hresp     = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_htrans", 32'(htrans), 32'd0);
        check("rst_haddr", haddr, 32'd0);
        check("rst_hwrite", 32'(hwrite), 32'd0);
        check("rst_hsize", 32'(hsize), 32'd0);
        check("rst_hwdata", hwdata, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_hburst", 32'(hburst), 32'd0);
        reset = 1'b0;

        // Read, zero wait states
        @(negedge clock);
        drive_cmd(0, 1'b0, 32'h0000_0010, 32'h0, 3'd2);
        hrdata = 32'hDEAD_BEEF;
        #1;
        check("t1_gnt", 32'(gnt), 32'd1);
        mdl_rdata = 32'hDEAD_BEEF;
        expect_done(2'b01, 1'b0, mdl_rdata, 3);
        @(negedge clock);
        req = '0;
        check("t1_htrans", 32'(htrans), 32'h2);
        check("t1_haddr", haddr, 32'h10);
        check("t1_hwrite", 32'(hwrite), 32'd0);
        check("t1_hsize", 32'(hsize), 32'd2);
        @(negedge clock);
        check("t1_dphase_htrans", 32'(htrans), 32'd0);
        @(negedge clock);

        // Write, two data-phase wait states
        drive_cmd(1, 1'b1, 32'h0000_0800, 32'h1234_5678, 3'd2);
        #1;
        check("t2_gnt", 32'(gnt), 32'h2);
        expect_done(2'b10, 1'b0, mdl_rdata, 5);
        @(negedge clock);
        req = '0;
        check("t2_htrans", 32'(htrans), 32'h2);
        check("t2_haddr", haddr, 32'h800);
        check("t2_hwrite", 32'(hwrite), 32'd1);
        @(negedge clock);
        hready = 1'b0;
        check("t2_dphase_htrans", 32'(htrans), 32'd0);
        check("t2_hwdata0", hwdata, 32'h1234_5678);
        @(negedge clock);
        check("t2_hwdata1", hwdata, 32'h1234_5678);
        @(negedge clock);
        hready = 1'b1;
        check("t2_hwdata2", hwdata, 32'h1234_5678);
        @(negedge clock);

        // Simultaneous requests held high
        for (int k = 0; k < 4; k++) begin
            drive_cmd(0, 1'b0, 32'h100 + 32'(k * 4), 32'h0, 3'd2);
            drive_cmd(1, 1'b0, 32'h200 + 32'(k * 4), 32'h0, 3'd2);
            hrdata = 32'hA000_0000 + 32'(k);
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            eg = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            eg = 2'b01;
`endif
            check("t3_gnt", 32'(gnt), 32'(eg));
            mdl_rdata = hrdata;
            expect_done(eg, 1'b0, mdl_rdata, 3);
            @(negedge clock);
            check("t3_gnt_busy", 32'(gnt), 32'd0);
            @(negedge clock);
            @(negedge clock);
        end
        req = '0;

        // ERROR response on a read, then a normal read
        drive_cmd(0, 1'b0, 32'h20, 32'h0, 3'd2);
        hrdata = 32'h0BAD_0BAD;
        #1;
        check("t4_gnt", 32'(gnt), 32'd1);
        mdl_rdata = 32'h0BAD_0BAD;
        expect_done(2'b01, 1'b1, mdl_rdata, 4);
        @(negedge clock);
        req = '0;
        @(negedge clock);
        hready = 1'b0;
        hresp  = 1'b1;
        @(negedge clock);
        hready = 1'b1;
        @(negedge clock);
        hresp = 1'b0;
        drive_cmd(0, 1'b0, 32'h30, 32'h0, 3'd2);
        hrdata = 32'h600D_F00D;
        #1;
        check("t4_next_gnt", 32'(gnt), 32'd1);
        mdl_rdata = 32'h600D_F00D;
        expect_done(2'b01, 1'b0, mdl_rdata, 3);
        @(negedge clock);
        req = '0;
        @(negedge clock);
        @(negedge clock);

        // Watchdog: hready stuck low in the address phase
        drive_cmd(0, 1'b0, 32'h40, 32'h0, 3'd2);
        #1;
        check("t5_gnt", 32'(gnt), 32'd1);
        expect_done(2'b01, 1'b1, mdl_rdata, 5);
        @(negedge clock);
        req    = '0;
        hready = 1'b0;
        check("t5_htrans_start", 32'(htrans), 32'h2);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        check("t5_htrans_held", 32'(htrans), 32'h2);
        check("t5_haddr_held", haddr, 32'h40);
        @(negedge clock);
        check("t5_htrans_abort", 32'(htrans), 32'd0);
        hready = 1'b1;
        drive_cmd(0, 1'b0, 32'h44, 32'h0, 3'd2);
        hrdata = 32'h5555_AAAA;
        #1;
        check("t5_idle_gnt", 32'(gnt), 32'd1);
        mdl_rdata = 32'h5555_AAAA;
        expect_done(2'b01, 1'b0, mdl_rdata, 3);
        @(negedge clock);
        req = '0;
        @(negedge clock);
        @(negedge clock);

        // Reset during the data phase
        drive_cmd(0, 1'b0, 32'h50, 32'h0, 3'd2);
        #1;
        check("t6_gnt", 32'(gnt), 32'd1);
        @(negedge clock);
        req = '0;
        @(negedge clock);
        hready = 1'b0;
        reset  = 1'b1;
        @(negedge clock);
        check("t6_htrans", 32'(htrans), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_haddr", haddr, 32'd0);
        check("t6_rdata", rdata, 32'd0);
        reset  = 1'b0;
        hready = 1'b1;
        drive_cmd(0, 1'b0, 32'h60, 32'h0, 3'd2);
        hrdata = 32'h1357_9BDF;
        #1;
        check("t6_gnt_after", 32'(gnt), 32'd1);
        mdl_rdata = 32'h1357_9BDF;
        expect_done(2'b01, 1'b0, mdl_rdata, 3);
        @(negedge clock);
        req = '0;

        // Drain outstanding predictions with a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
        @(negedge clock);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
